dmem_io_controller: RTL and testbench
=====================================

Name: dmem_io_controller

Overview:
- Data-memory and memory-mapped IO device on the PMIPSL1 MEM-stage bus; directly downstream of the processor's data-memory port.
- Holds word-organised data RAM, one display register driving the 7-segment output, and two synchronised, debounced slide-switch inputs.
- Supplies read data combinationally in the same cycle, so the pipeline MEM stage needs no stall.

Parameters:
- DEPTH, 128, number of 16-bit RAM words; power of two, at most 32768.
- DEBOUNCE_CYCLES, 4, consecutive clock cycles a synchronised switch level must hold before it is accepted; at least 1.
- IO_BASE, 16'hFFF0, base byte address of the IO window.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset. Asserting low clears state immediately; release is sampled on the clock.
- dmemaddr  in  16  byte address; bit 0 ignored; word index = dmemaddr[log2(DEPTH):1].
- dmemwdata  in  16  write data.
- dmemwrite  in  1  write enable.
- dmemread  in  1  read enable.
- io_sw0  in  1  raw slide switch 0 (asynchronous).
- io_sw1  in  1  raw slide switch 1 (asynchronous).
- dmemrdata  out  16  read data.
- io_display  out  7  segments {g,f,e,d,c,b,a}, active-high = lit.

Behaviour:
Address map:
- RAM: addresses below DEPTH*2.
- IO_BASE+0: display register. Write only; reads return 0.
- IO_BASE+2: switch 0. Read returns {15'b0, sw0_db}.
- IO_BASE+4: switch 1. Read returns {15'b0, sw1_db}.
- Any other address: writes ignored; reads return 0.

Writes:
- When dmemwrite=1, the addressed RAM word or display register updates on the rising edge.
- disp_reg[15:0] is updated only by writes to IO_BASE+0.

Reads:
- dmemrdata is combinational.
- When dmemread=0, dmemrdata = 16'h0000.
- Read and write to the same address in the same cycle: read returns the pre-edge (old) value. The new value is visible from the next cycle.
- dmemread=1 and dmemwrite=1 to different addresses: both proceed independently.

Switch path (per switch):
- Two-flop synchroniser feeds sw_sync.
- Debounce counter cnt, width ceil(log2(DEBOUNCE_CYCLES+1)).
- Each cycle: if sw_sync == sw_db, cnt <= 0. Otherwise cnt <= cnt+1.
- When cnt == DEBOUNCE_CYCLES-1 and sw_sync != sw_db still holds: sw_db <= sw_sync and cnt <= 0.
- A glitch shorter than DEBOUNCE_CYCLES cycles is never accepted.
- Total latency from a raw edge to a visible change in sw_db: 2 + DEBOUNCE_CYCLES cycles.

Reset (reset=0):
- disp_reg=0, so io_display shows "0" (7'b0111111).
- Synchroniser flops, sw_db and cnt cleared to 0.
- RAM contents are not reset.
- Reset asserted mid-debounce discards the partial count.
- A write coincident with reset assertion is lost.

Display:
- io_display is registered from disp_reg and updates one cycle after the write edge.

Optional Feature:
- HEX_DECODE_EN defined: io_display = hex 7-segment encoding of disp_reg[3:0], digits 0-F. Examples: 0 gives 7'b0111111, 5 gives 7'b1101101, A gives 7'b1110111.
- HEX_DECODE_EN undefined: io_display = disp_reg[6:0] raw, so software drives the segments directly. Reset value is then 7'b0000000.
- Address map and all other behaviour are identical in both builds.

Test Plan:
1. Reset low at t=0, release, no accesses -> io_display=7'b0111111 (HEX_DECODE_EN) or 7'b0000000 (raw); dmemrdata=0.
2. Write 16'h1234 to address 16'h0006, next cycle read 16'h0006 -> dmemrdata=16'h1234. In the write cycle itself, a read of 16'h0006 returns the prior value.
3. Write 16'h0005 to 16'hFFF0 -> one cycle later io_display=7'b1101101 (HEX_DECODE_EN) or 7'b0000101 (raw).
4. io_sw0 held 1 with DEBOUNCE_CYCLES=4 -> read of 16'hFFF2 returns 1 exactly 6 cycles after the edge. A 3-cycle pulse on io_sw1 -> read of 16'hFFF4 stays 0.
5. Write 16'hBEEF to 16'h0100 (DEPTH=128, out of range) and to 16'hFFF6 -> no RAM or display change; reads of both return 0.
6. Assert reset low mid-debounce (cycle 3 of a switch change) and mid-display-value 16'h000A -> sw_db=0 and io_display back to reset value immediately, without waiting for a clock edge. RAM word written before reset still reads back.

Source files
------------

// File: rtl/dmem_io_controller.sv
`default_nettype none
// ============================================================================
// Module   : dmem_io_controller
// Brief    : MEM-stage data RAM plus memory-mapped IO: one 7-segment display
//            register and two synchronised, debounced slide switches.
//            Read data is combinational so the MEM stage never stalls.
//            Optional build macro HEX_DECODE_EN: display shows the hex digit
//            of disp_reg[3:0]; otherwise disp_reg[6:0] drives segments raw.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_io_controller #(
    parameter int          DEPTH           = 128,
    parameter int          DEBOUNCE_CYCLES = 4,
    parameter logic [15:0] IO_BASE         = 16'hFFF0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] dmemaddr,
    input  logic [15:0] dmemwdata,
    input  logic        dmemwrite,
    input  logic        dmemread,
    input  logic        io_sw0,
    input  logic        io_sw1,
    output logic [15:0] dmemrdata,
    output logic [6:0]  io_display
);

    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_cnt_w  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] c_io_disp = IO_BASE;
    localparam logic [15:0] c_io_sw0  = IO_BASE + 16'd2;
    localparam logic [15:0] c_io_sw1  = IO_BASE + 16'd4;
    localparam logic [16:0] c_ram_top = 17'(2 * DEPTH);

`ifdef HEX_DECODE_EN
    localparam logic [6:0] c_disp_rst = 7'b0111111;

    // Segment pattern {g,f,e,d,c,b,a} for one hex digit
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0:    hex7 = 7'b0111111;
            4'h1:    hex7 = 7'b0000110;
            4'h2:    hex7 = 7'b1011011;
            4'h3:    hex7 = 7'b1001111;
            4'h4:    hex7 = 7'b1100110;
            4'h5:    hex7 = 7'b1101101;
            4'h6:    hex7 = 7'b1111101;
            4'h7:    hex7 = 7'b0000111;
            4'h8:    hex7 = 7'b1111111;
            4'h9:    hex7 = 7'b1101111;
            4'hA:    hex7 = 7'b1110111;
            4'hB:    hex7 = 7'b1111100;
            4'hC:    hex7 = 7'b0111001;
            4'hD:    hex7 = 7'b1011110;
            4'hE:    hex7 = 7'b1111001;
            default: hex7 = 7'b1110001;
        endcase
    endfunction
`else
    localparam logic [6:0] c_disp_rst = 7'b0000000;
`endif

    logic [15:0]         w_word_addr;
    logic                w_sel_disp;
    logic                w_sel_sw0;
    logic                w_sel_sw1;
    logic                w_sel_ram;
    logic [c_addr_w-1:0] w_ram_idx;
    logic [1:0]          w_sw_raw;
    logic [1:0]          w_sw_db;
    logic [6:0]          w_disp_next;

    logic [15:0]         r_mem [DEPTH];
    logic [15:0]         r_disp_reg;
    logic [6:0]          r_display;

    // Address decode; bit 0 is ignored everywhere. IO decode wins over RAM
    // so the IO window stays reachable even at the largest DEPTH.
    assign w_word_addr = {dmemaddr[15:1], 1'b0};
    assign w_sel_disp  = (w_word_addr == c_io_disp);
    assign w_sel_sw0   = (w_word_addr == c_io_sw0);
    assign w_sel_sw1   = (w_word_addr == c_io_sw1);
    assign w_sel_ram   = ({1'b0, dmemaddr} < c_ram_top) &&
                         !(w_sel_disp || w_sel_sw0 || w_sel_sw1);
    assign w_ram_idx   = dmemaddr[c_addr_w:1];
    assign w_sw_raw    = {io_sw1, io_sw0};

    // RAM write port; contents are kept across reset, and a write presented
    // while reset is low is dropped
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
        end else if (dmemwrite && w_sel_ram) begin
            r_mem[w_ram_idx] <= dmemwdata;
        end
    end

    // Display value register, written only through the display address
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_disp_reg <= 16'h0000;
        end else if (dmemwrite && w_sel_disp) begin
            r_disp_reg <= dmemwdata;
        end
    end

`ifdef HEX_DECODE_EN
    assign w_disp_next = hex7(r_disp_reg[3:0]);
`else
    assign w_disp_next = r_disp_reg[6:0];
`endif

    // Segment output register, one cycle behind the display value register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_display <= c_disp_rst;
        end else begin
            r_display <= w_disp_next;
        end
    end

    assign io_display = r_display;

    // Per-switch two-flop synchroniser followed by a hold-time debouncer
    for (genvar gi = 0; gi < 2; gi++) begin : g_sw
        logic               r_meta;
        logic               r_sync;
        logic               r_db;
        logic [c_cnt_w-1:0] r_cnt;

        // Synchronise and accept a new level only after it holds long enough
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_meta <= 1'b0;
                r_sync <= 1'b0;
                r_db   <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_meta <= w_sw_raw[gi];
                r_sync <= r_meta;
                if (r_sync == r_db) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_cnt_last) begin
                    r_db  <= r_sync;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_sw_db[gi] = r_db;
    end

    // Combinational read mux; idle bus and unmapped addresses read as zero
    always_comb begin
        dmemrdata = 16'h0000;
        if (dmemread) begin
            if (w_sel_sw0) begin
                dmemrdata = {15'b0, w_sw_db[0]};
            end else if (w_sel_sw1) begin
                dmemrdata = {15'b0, w_sw_db[1]};
            end else if (w_sel_ram) begin
                dmemrdata = r_mem[w_ram_idx];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_io_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_io_controller
// Brief    : Scoreboard bench for dmem_io_controller (RAM, display, switches,
//            reset behaviour). Expected values are queued when stimulus is
//            driven and popped when the DUT output is sampled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_io_controller;

`ifdef HEX_DECODE_EN
    localparam logic [6:0] c_disp_rst = 7'b0111111;
    localparam logic [6:0] c_disp_5   = 7'b1101101;
    localparam logic [6:0] c_disp_a   = 7'b1110111;
`else
    localparam logic [6:0] c_disp_rst = 7'b0000000;
    localparam logic [6:0] c_disp_5   = 7'b0000101;
    localparam logic [6:0] c_disp_a   = 7'b0001010;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] dmemaddr = 16'h0;
    logic [15:0] dmemwdata = 16'h0;
    logic        dmemwrite = 1'b0;
    logic        dmemread = 1'b0;
    logic        io_sw0 = 1'b0;
    logic        io_sw1 = 1'b0;
    logic [15:0] dmemrdata;
    logic [6:0]  io_display;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_q [$];
    logic [6:0]  dexp_q [$];
    logic [15:0] model [128];
    logic [15:0] e;
    logic [6:0]  de;

    dmem_io_controller #(
        .DEPTH(128), .DEBOUNCE_CYCLES(4), .IO_BASE(16'hFFF0)
    ) dut (
        .clock(clock), .reset(reset), .dmemaddr(dmemaddr),
        .dmemwdata(dmemwdata), .dmemwrite(dmemwrite), .dmemread(dmemread),
        .io_sw0(io_sw0), .io_sw1(io_sw1), .dmemrdata(dmemrdata),
        .io_display(io_display)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        dmemaddr  = a;
        dmemwdata = d;
        dmemwrite = 1'b1;
        cyc();
        dmemwrite = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
        dmemread = 1'b0;
        dmemaddr = 16'h0006;
        exp_q.push_back(16'h0000);
        dexp_q.push_back(c_disp_rst);
        #1;
        n_tests++; e = exp_q.pop_front();
        if (dmemrdata !== e) begin n_fail++; $display("FAIL reset_rdata got=%h exp=%h", dmemrdata, e); end
        n_tests++; de = dexp_q.pop_front();
        if (io_display !== de) begin n_fail++; $display("FAIL reset_display got=%b exp=%b", io_display, de); end
        cyc();
        dmemread = 1'b1;
        dmemaddr = 16'hFFF2;
        exp_q.push_back(16'h0000);
        #1;
        n_tests++; e = exp_q.pop_front();
        if (dmemrdata !== e) begin n_fail++; $display("FAIL reset_sw0 got=%h exp=%h", dmemrdata, e); end
        dmemread = 1'b0;
    endtask

    task automatic test_ram_rw();
        logic [15:0] addrs [5];
        addrs = '{16'h0000, 16'h0002, 16'h0006, 16'h0080, 16'h00FE};
        foreach (addrs[i]) begin
            model[addrs[i][7:1]] = 16'($urandom);
            wr(addrs[i], model[addrs[i][7:1]]);
        end
        dmemread = 1'b1;
        foreach (addrs[i]) begin
            dmemaddr = addrs[i];
            exp_q.push_back(model[addrs[i][7:1]]);
            #1;
            n_tests++; e = exp_q.pop_front();
            if (dmemrdata !== e) begin n_fail++; $display("FAIL ram_rd addr=%h got=%h exp=%h", addrs[i], dmemrdata, e); end
        end
        cyc();
        // same-cycle read and write: old value now, new value after the edge
        dmemaddr  = 16'h0006;
        dmemwdata = 16'h1234;
        dmemwrite = 1'b1;
        exp_q.push_back(model[3]);
        #1;
        n_tests++; e = exp_q.pop_front();
        if (dmemrdata !== e) begin n_fail++; $display("FAIL rw_same_old got=%h exp=%h", dmemrdata, e); end
        model[3] = 16'h1234;
        cyc();
        dmemwrite = 1'b0;
        exp_q.push_back(model[3]);
        #1;
        n_tests++; e = exp_q.pop_front();
        if (dmemrdata !== e) begin n_fail++; $display("FAIL rw_same_new got=%h exp=%h", dmemrdata, e); end
        dmemaddr = 16'h0007;
        exp_q.push_back(16'h1234);
        #1;
        n_tests++; e = exp_q.pop_front();
        if (dmemrdata !== e) begin n_fail++; $display("FAIL ram_bit0 got=%h exp=%h", dmemrdata, e); end
        dmemread = 1'b0;
        exp_q.push_back(16'h0000);
        #1;
        n_tests++; e = exp_q.pop_front();
        if (dmemrdata !== e) begin n_fail++; $display("FAIL ram_noread got=%h exp=%h", dmemrdata, e); end
    endtask

    task automatic test_display();
        cyc();
        wr(16'hFFF0, 16'h0005);
        dexp_q.push_back(c_disp_rst);
        n_tests++; de = dexp_q.pop_front();
        if (io_display !== de) begin n_fail++; $display("FAIL disp_lag got=%b exp=%b", io_display, de); end
        cyc();
        dexp_q.push_back(c_disp_5);
        n_tests++; de = dexp_q.pop_front();
        if (io_display !== de) begin n_fail++; $display("FAIL disp_5 got=%b exp=%b", io_display, de); end
        dmemread = 1'b1;
        dmemaddr = 16'hFFF0;
        exp_q.push_back(16'h0000);
        #1;
        n_tests++; e = exp_q.pop_front();
        if (dmemrdata !== e) begin n_fail++; $display("FAIL disp_read got=%h exp=%h", dmemrdata, e); end
        dmemread = 1'b0;
    endtask

    task automatic test_out_of_range();
        cyc();
        wr(16'h0100, 16'hBEEF);
        wr(16'hFFF6, 16'hBEEF);
        cyc();
        dexp_q.push_back(c_disp_5);
        n_tests++; de = dexp_q.pop_front();
        if (io_display !== de) begin n_fail++; $display("FAIL oor_display got=%b exp=%b", io_display, de); end
        dmemread = 1'b1;
        dmemaddr = 16'h0100;
        exp_q.push_back(16'h0000);
        #1;
        n_tests++; e = exp_q.pop_front();
        if (dmemrdata !== e) begin n_fail++; $display("FAIL oor_rd_0100 got=%h exp=%h", dmemrdata, e); end
        dmemaddr = 16'hFFF6;
        exp_q.push_back(16'h0000);
        #1;
        n_tests++; e = exp_q.pop_front();
        if (dmemrdata !== e) begin n_fail++; $display("FAIL oor_rd_fff6 got=%h exp=%h", dmemrdata, e); end
        dmemaddr = 16'h0000;
        exp_q.push_back(model[0]);
        #1;
        n_tests++; e = exp_q.pop_front();
        if (dmemrdata !== e) begin n_fail++; $display("FAIL oor_alias got=%h exp=%h", dmemrdata, e); end
        dmemread = 1'b0;
    endtask

    task automatic test_switch();
        cyc();
        dmemread = 1'b1;
        dmemaddr = 16'hFFF2;
        io_sw0   = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            exp_q.push_back((k >= 6) ? 16'h0001 : 16'h0000);
            cyc();
            n_tests++; e = exp_q.pop_front();
            if (dmemrdata !== e) begin n_fail++; $display("FAIL sw0_latency cyc=%0d got=%h exp=%h", k, dmemrdata, e); end
        end
        dmemaddr = 16'hFFF4;
        io_sw1   = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            exp_q.push_back(16'h0000);
            cyc();
            if (k == 3) io_sw1 = 1'b0;
            n_tests++; e = exp_q.pop_front();
            if (dmemrdata !== e) begin n_fail++; $display("FAIL sw1_glitch cyc=%0d got=%h exp=%h", k, dmemrdata, e); end
        end
        dmemread = 1'b0;
    endtask

    task automatic test_reset_mid();
        wr(16'hFFF0, 16'h000A);
        cyc();
        dexp_q.push_back(c_disp_a);
        n_tests++; de = dexp_q.pop_front();
        if (io_display !== de) begin n_fail++; $display("FAIL disp_a got=%b exp=%b", io_display, de); end
        io_sw1 = 1'b1;
        repeat (4) cyc();
        #2;
        reset = 1'b0;
        dexp_q.push_back(c_disp_rst);
        #1;
        n_tests++; de = dexp_q.pop_front();
        if (io_display !== de) begin n_fail++; $display("FAIL rstmid_display got=%b exp=%b", io_display, de); end
        dmemread = 1'b1;
        dmemaddr = 16'hFFF2;
        exp_q.push_back(16'h0000);
        #1;
        n_tests++; e = exp_q.pop_front();
        if (dmemrdata !== e) begin n_fail++; $display("FAIL rstmid_sw0 got=%h exp=%h", dmemrdata, e); end
        dmemaddr = 16'h0006;
        exp_q.push_back(model[3]);
        #1;
        n_tests++; e = exp_q.pop_front();
        if (dmemrdata !== e) begin n_fail++; $display("FAIL rstmid_ram got=%h exp=%h", dmemrdata, e); end
        cyc();
        cyc();
        reset = 1'b1;
        dmemaddr = 16'hFFF4;
        for (int k = 1; k <= 6; k++) begin
            exp_q.push_back((k >= 6) ? 16'h0001 : 16'h0000);
            cyc();
            n_tests++; e = exp_q.pop_front();
            if (dmemrdata !== e) begin n_fail++; $display("FAIL rstmid_sw1 cyc=%0d got=%h exp=%h", k, dmemrdata, e); end
        end
        dexp_q.push_back(c_disp_rst);
        n_tests++; de = dexp_q.pop_front();
        if (io_display !== de) begin n_fail++; $display("FAIL rstmid_disp_after got=%b exp=%b", io_display, de); end
        dmemaddr = 16'h0006;
        exp_q.push_back(16'h1234);
        #1;
        n_tests++; e = exp_q.pop_front();
        if (dmemrdata !== e) begin n_fail++; $display("FAIL rstmid_ram_after got=%h exp=%h", dmemrdata, e); end
        dmemread = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ram_rw();
        test_display();
        test_out_of_range();
        test_switch();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
